// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// byte width and a counter-width helper.
package uart_tx_arbiter_pkg;

    localparam int UART_DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_WAIT_DONE  = 2'd2,
        ST_GAP        = 2'd3
    } state_t;

    // Width for a counter that must hold max_val; never narrower than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first valid requester searching upward
// from last+1, wrapping.
module uart_rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_valid,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] winner
);

    int best;

    // Each requester's distance past `last`; the smallest valid distance wins.
    always_comb begin
        any    = |req_valid;
        winner = '0;
        best   = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && (((i - int'(last) - 1 + 2 * NREQ) % NREQ) < best)) begin
                best   = (i - int'(last) - 1 + 2 * NREQ) % NREQ;
                winner = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NREQ byte sources with round-robin
// priority, tracking tx_busy so no frame is overwritten.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int START_TO = 16,
    parameter int GAP      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [UART_DW*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      tx_busy,
    output logic [UART_DW-1:0]        dataout,
    output logic                      wrsig,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      start_err,
    output state_t                    fsm_state
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int TO_W  = cnt_w(START_TO);
    localparam int GAP_W = cnt_w(GAP);

    // Handshake: a requester holds req_valid and its byte until it sees the
    // one-cycle req_ready pulse, which coincides with wrsig; dropping valid
    // earlier simply withdraws the request.
    state_t               state, state_nxt;
    logic [IDX_W-1:0]     last, last_nxt;
    logic [TO_W-1:0]      to_cnt, to_cnt_nxt;
    logic [GAP_W-1:0]     gap_cnt, gap_cnt_nxt;
    logic [UART_DW-1:0]   dataout_nxt;
    logic                 wrsig_nxt;
    logic [NREQ-1:0]      req_ready_nxt;
    logic [IDX_W-1:0]     grant_id_nxt;
    logic                 start_err_nxt;
    logic                 any;
    logic [IDX_W-1:0]     winner;

    uart_rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
        .req_valid (req_valid),
        .last      (last),
        .any       (any),
        .winner    (winner)
    );

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            last      <= IDX_W'(NREQ - 1);
            to_cnt    <= '0;
            gap_cnt   <= '0;
            dataout   <= '0;
            wrsig     <= 1'b0;
            req_ready <= '0;
            grant_id  <= '0;
            start_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            to_cnt    <= to_cnt_nxt;
            gap_cnt   <= gap_cnt_nxt;
            dataout   <= dataout_nxt;
            wrsig     <= wrsig_nxt;
            req_ready <= req_ready_nxt;
            grant_id  <= grant_id_nxt;
            start_err <= start_err_nxt;
        end
    end

    // Counters default to zero so every state entry starts them cleared.
    always_comb begin
        state_nxt     = state;
        last_nxt      = last;
        to_cnt_nxt    = '0;
        gap_cnt_nxt   = '0;
        dataout_nxt   = dataout;
        wrsig_nxt     = 1'b0;
        req_ready_nxt = '0;
        grant_id_nxt  = grant_id;
        start_err_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any && !tx_busy) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (winner == IDX_W'(i)) begin
                            dataout_nxt = req_data[UART_DW*i +: UART_DW];
                        end
                    end
                    wrsig_nxt     = 1'b1;
                    req_ready_nxt = NREQ'(1) << winner;
                    grant_id_nxt  = winner;
                    last_nxt      = winner;
                    state_nxt     = ST_WAIT_START;
                end
            end
            ST_WAIT_START: begin
                if (tx_busy) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (to_cnt == TO_W'(START_TO - 1)) begin
                    start_err_nxt = 1'b1;
                    state_nxt     = ST_GAP;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nxt = (GAP == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (int'(gap_cnt) + 1 >= GAP) begin
                    state_nxt = ST_IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
